// File: rtl/smg_disp_ctrl_if.sv
// Requester handshake and display bus of the seven-segment display controller.
// master = requesters / display consumer side, slave = controller side.
interface smg_disp_ctrl_if;
    logic        REQ_A;
    logic [15:0] DATA_A;
    logic        ACK_A;
    logic        REQ_B;
    logic [15:0] DATA_B;
    logic        ACK_B;
    logic [2:0]  SEL;
    logic [3:0]  CODE;
    logic        BUSY;
    logic        OVF;

    modport master (
        output REQ_A, DATA_A, REQ_B, DATA_B,
        input  ACK_A, ACK_B, SEL, CODE, BUSY, OVF
    );

    modport slave (
        input  REQ_A, DATA_A, REQ_B, DATA_B,
        output ACK_A, ACK_B, SEL, CODE, BUSY, OVF
    );
endinterface

// File: rtl/smg_disp_ctrl.sv
// Two-requester, round-robin display controller: binary capture, shift-and-add-3 BCD, 4-digit scan.
// Optional macro SMG_LEAD_ZERO_BLANK_EN blanks leading zeros in thousands..tens.
module smg_disp_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic         CLK,
    input logic         RST,
    smg_disp_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [35:0] sh_q, sh_d;      // {bcd[19:0], bin[15:0]}
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        last_b_q, last_b_d;
    logic        grant_b;
    logic [15:0] cap_data;
    logic [19:0] bcd_adj;
    logic [19:0] div_q;
    logic [1:0]  sel_q;
    logic [3:0]  digit;
    logic [3:0]  code;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            last_b_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            last_b_q   <= last_b_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            bcd_adj[4*i +: 4] = (sh_q[16+4*i +: 4] >= 4'd5) ? sh_q[16+4*i +: 4] + 4'd3
                                                           : sh_q[16+4*i +: 4];
        end
    end

    assign grant_b  = bus.REQ_B && (!bus.REQ_A || !last_b_q);
    assign cap_data = grant_b ? bus.DATA_B : bus.DATA_A;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        last_b_d   = last_b_q;
        case (state_q)
            IDLE: begin
                if (bus.REQ_A || bus.REQ_B) begin
                    sh_d       = {20'd0, cap_data};
                    ovf_pend_d = cap_data > 16'd9999;
                    ack_a_d    = !grant_b;
                    ack_b_d    = grant_b;
                    last_b_d   = grant_b;
                    cnt_d      = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                // First CONV cycle overlaps the ACK pulse; the 16 shifts follow it.
                cnt_d = cnt_q + 5'd1;
                if (cnt_q != 5'd0) begin
                    sh_d = {bcd_adj, sh_q[15:0]} << 1;
                end
                if (cnt_q == 5'd16) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = ovf_pend_q ? 16'hEEEE : sh_q[31:16];
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan runs free of the FSM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q <= '0;
            sel_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            sel_q <= sel_q + 2'd1;
        end else begin
            div_q <= div_q + 20'd1;
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    digit = disp_q[15:12];
            2'd1:    digit = disp_q[11:8];
            2'd2:    digit = disp_q[7:4];
            default: digit = disp_q[3:0];
        endcase
        code = digit;
`ifdef SMG_LEAD_ZERO_BLANK_EN
        // Error digits are nonzero, so they never match the blanking test.
        case (sel_q)
            2'd0:    if (disp_q[15:12] == 4'd0) code = 4'hF;
            2'd1:    if (disp_q[15:8] == 8'd0) code = 4'hF;
            2'd2:    if (disp_q[15:4] == 12'd0) code = 4'hF;
            default: code = digit;
        endcase
`endif
    end

    assign bus.ACK_A = ack_a_q;
    assign bus.ACK_B = ack_b_q;
    assign bus.SEL   = {1'b0, sel_q};
    assign bus.CODE  = code;
    assign bus.BUSY  = (state_q != IDLE);
    assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_smg_disp_ctrl.sv
// Self-checking bench for smg_disp_ctrl (SCAN_DIV=4) against a cycle-level behavioural model.
module tb_smg_disp_ctrl;

    logic CLK = 1'b0;
    logic RST;

    smg_disp_ctrl_if bus ();

    smg_disp_ctrl #(.SCAN_DIV(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_busy;      // cycles of BUSY remaining after the current edge
    int m_cap;       // captured value awaiting display
    int m_disp;      // value currently displayed
    bit m_ovf;
    bit m_last_b;
    int m_edges;     // rising edges since reset release
    bit m_ack_a, m_ack_b;
    bit got_a, got_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cap = 0; m_disp = 0; m_ovf = 0; m_last_b = 1; m_edges = 0;
        m_ack_a = 0; m_ack_b = 0; got_a = 0; got_b = 0;
    endtask

    task automatic model_edge();
        bit gb;
        m_ack_a = 0; m_ack_b = 0; got_a = 0; got_b = 0;
        m_edges++;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_disp = m_cap;
                m_ovf  = (m_cap > 9999);
            end
        end else if (bus.REQ_A || bus.REQ_B) begin
            gb = bus.REQ_B && (!bus.REQ_A || !m_last_b);
            m_cap    = gb ? int'(bus.DATA_B) : int'(bus.DATA_A);
            m_last_b = gb;
            m_ack_a  = !gb; m_ack_b = gb;
            got_a    = !gb; got_b = gb;
            m_busy   = 18;
        end
    endtask

    function automatic logic [3:0] exp_code(input int sel);
        int pw;
        pw = (sel == 0) ? 1000 : (sel == 1) ? 100 : (sel == 2) ? 10 : 1;
        if (m_ovf) return 4'hE;
`ifdef SMG_LEAD_ZERO_BLANK_EN
        if (sel < 3 && m_disp < pw) return 4'hF;
`endif
        return 4'((m_disp / pw) % 10);
    endfunction

    task automatic check_all();
        int s;
        s = (m_edges / 4) % 4;
        chk("SEL",   32'(bus.SEL),   32'(s));
        chk("CODE",  32'(bus.CODE),  32'(exp_code(s)));
        chk("BUSY",  32'(bus.BUSY),  32'(m_busy > 0));
        chk("OVF",   32'(bus.OVF),   32'(m_ovf));
        chk("ACK_A", 32'(bus.ACK_A), 32'(m_ack_a));
        chk("ACK_B", 32'(bus.ACK_B), 32'(m_ack_b));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases it on a later falling edge.
    task automatic do_reset();
        #2 RST = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check_all();
        RST = 1'b0;
    endtask

    // Holds each selected request until the model sees it granted.
    task automatic serve(input bit use_a, input logic [15:0] va,
                         input bit use_b, input logic [15:0] vb);
        bit pa, pb;
        pa = use_a; pb = use_b;
        bus.DATA_A = va; bus.DATA_B = vb;
        for (int n = 0; n < 60 && (pa || pb); n++) begin
            bus.REQ_A = pa; bus.REQ_B = pb;
            tick();
            if (got_a) pa = 0;
            if (got_b) pb = 0;
        end
        bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        case ($urandom % 3)
            0:       return 16'($urandom_range(0, 99));
            1:       return 16'($urandom_range(0, 9999));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        RST = 1'b1;
        bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
        bus.DATA_A = '0;  bus.DATA_B = '0;
        model_reset();
        @(negedge CLK);
        do_reset();

        // Idle scan
        ticks(20);

        // Single request A = 1234
        serve(1'b1, 16'd1234, 1'b0, 16'd0);
        ticks(20);

        // Simultaneous A = 42, B = 777
        serve(1'b1, 16'd42, 1'b1, 16'd777);
        ticks(20);

        // Overflow then 9999
        serve(1'b0, 16'd0, 1'b1, 16'd12000);
        ticks(20);
        serve(1'b0, 16'd0, 1'b1, 16'd9999);
        ticks(20);

        // Reset during conversion with request still held
        bus.DATA_A = 16'd5678; bus.REQ_A = 1'b1;
        tick();
        ticks(8);
        do_reset();
        tick();
        bus.REQ_A = 1'b0;
        ticks(20);

        // One-cycle REQ_A pulse while busy
        serve(1'b0, 16'd0, 1'b1, 16'd321);
        ticks(3);
        bus.DATA_A = 16'd1111; bus.REQ_A = 1'b1;
        tick();
        bus.REQ_A = 1'b0;
        ticks(20);

        // Randomized traffic
        for (int k = 0; k < 12; k++) begin
            case ($urandom % 3)
                0:       serve(1'b1, rand_val(), 1'b0, 16'd0);
                1:       serve(1'b0, 16'd0, 1'b1, rand_val());
                default: serve(1'b1, rand_val(), 1'b1, rand_val());
            endcase
            ticks($urandom_range(0, 25));
        end
        ticks(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/smg_disp_ctrl.md
SMG_DISP_CTRL -- requirements
Module: smg_disp_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is held before SEL advances (legal range 2..2^20).
REQ-002 SHALL have port CLK, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port REQ_A, input, 1, requester A (distance source) holds high while DATA_A is valid.
REQ-005 SHALL have port DATA_A, input, 16, requester A binary value.
REQ-006 SHALL have port ACK_A, output, 1, one-cycle pulse: DATA_A captured.
REQ-007 SHALL have ports REQ_B, DATA_B, ACK_B, identical in width and meaning for requester B.
REQ-008 SHALL have port SEL, output, 3, digit select 0..3 (0 = thousands, 3 = units).
REQ-009 SHALL have port CODE, output, 4, digit code for current SEL: 0..9 = BCD, 4'hE = error, 4'hF = blank.
REQ-010 SHALL have port BUSY, output, 1, high from capture through display load.
REQ-011 SHALL have port OVF, output, 1, high while the displayed value exceeds 9999.

Function
REQ-012 SHALL implement FSM IDLE -> CONV -> LOAD -> IDLE.
REQ-013 In IDLE, on an edge where REQ_A or REQ_B is high, SHALL capture the granted DATA, pulse the matching ACK for exactly the following cycle, set BUSY, enter CONV.
REQ-014 When REQ_A and REQ_B are both high at the same edge, SHALL grant the requester not granted last (round-robin); after reset A has priority.
REQ-015 Requests while BUSY SHALL receive no ACK and SHALL NOT be lost if the requester holds REQ; they are arbitrated on return to IDLE.
REQ-016 CONV SHALL perform binary-to-BCD by shift-and-add-3, one bit per cycle, exactly 16 cycles.
REQ-017 LOAD SHALL, in one cycle, write the four BCD digits into the display register, update OVF, clear BUSY, return to IDLE.
REQ-018 Latency: display register and OVF SHALL change 18 cycles after the capture edge (1 ACK + 16 CONV + 1 LOAD); next capture no earlier than the following edge.
REQ-019 If the captured value > 9999, LOAD SHALL set OVF=1 and all four display digits to 4'hE; otherwise OVF=0.
REQ-020 Prescaler SHALL count 0..SCAN_DIV-1 continuously, independent of FSM; at terminal count SEL SHALL advance 0,1,2,3,0 (wrap 3->0).
REQ-021 CODE SHALL be a combinational function of SEL and display register; a LOAD mid-digit SHALL take effect in that same digit slot next cycle.
REQ-022 REQ dropping before capture SHALL cause no capture; ACK never asserts without a capture.

Reset
REQ-023 RST high SHALL immediately force: state IDLE, ACK_A=ACK_B=0, BUSY=0, OVF=0, SEL=0, prescaler=0, display register = 0000, round-robin pointer to "B last".
REQ-024 RST asserted during CONV or LOAD SHALL abandon the conversion; no partial value ever reaches the display register.

Configuration
REQ-025 Macro SMG_LEAD_ZERO_BLANK_EN: when defined, CODE SHALL be 4'hF for every leading zero digit in thousands..tens positions (units always shown; error digits never blanked); when undefined, all four digits SHALL show their BCD value including leading zeros.

Verification (SCAN_DIV=4)
REQ-026 Reset release, no requests -> SEL cycles 0,1,2,3 every 4 cycles; CODE=0 all digits (macro off) or F,F,F,0 (macro on); BUSY=OVF=0.
REQ-027 REQ_A with DATA_A=1234 -> ACK_A one cycle after capture; display reads 1,2,3,4 exactly 18 cycles after capture; BUSY high for those 18 cycles.
REQ-028 REQ_A and REQ_B rise together (A=0042, B=0777), both held -> A granted first, B granted on first IDLE edge after LOAD; final display 0,7,7,7; macro on shows F,7,7,7 and earlier F,F,4,2.
REQ-029 REQ_B with DATA_B=12000 -> OVF=1, CODE=E for all four SEL values; then DATA_B=9999 -> OVF=0, display 9,9,9,9.
REQ-030 RST pulsed 8 cycles into CONV of 5678 -> display stays 0000, BUSY=0, no ACK repeat; after release, held REQ re-captured, 5678 displayed 18 cycles later.
REQ-031 REQ_A pulsed high one cycle while BUSY -> no ACK_A, display unchanged by that pulse.
